// File: rtl/pu_riscv_verilog_pkg.sv
// Shared RISC-V definitions: memory access sizes, data-memory responder
// state encoding and the size-to-byte-enable helper.
package pu_riscv_verilog_pkg;

  localparam logic [2:0] BYTE       = 3'b000;
  localparam logic [2:0] HWORD      = 3'b001;
  localparam logic [2:0] WORD       = 3'b010;
  localparam logic [2:0] DWORD      = 3'b011;
  localparam logic [2:0] UNDEF_SIZE = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RDATA,
    ERR
  } dmem_state_t;

  // Byte-enable mask for an access at byte offset 0; unknown sizes enable nothing
  function automatic logic [7:0] size2be(input logic [2:0] size);
    case (size)
      BYTE:    size2be = 8'h01;
      HWORD:   size2be = 8'h03;
      WORD:    size2be = 8'h0F;
      DWORD:   size2be = 8'hFF;
      default: size2be = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/pu_riscv_dmem_ram.sv
// Single-port data RAM with per-byte write enables and one-cycle read latency.
// Lives at SoC level next to pu_riscv_dmem_responder.
module pu_riscv_dmem_ram #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     mem_en,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_adr,
  input  logic [XLEN/8-1:0]        mem_be,
  input  logic [XLEN-1:0]          mem_d,
  output logic [XLEN-1:0]          mem_q
);

  logic [XLEN-1:0] ram [DEPTH];

  // mem_q keeps the last read word across writes and idle cycles
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < XLEN/8; i++) begin
          if (mem_be[i]) ram[mem_adr][i*8 +: 8] <= mem_d[i*8 +: 8];
        end
      end else begin
        mem_q <= ram[mem_adr];
      end
    end
  end

endmodule

// File: rtl/pu_riscv_dmem_responder.sv
// Data-memory responder: turns load/store strobes into RAM accesses, checks
// alignment and range, and buffers one request that arrives while busy.
module pu_riscv_dmem_responder
  import pu_riscv_verilog_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     dmem_req,
  input  logic [XLEN-1:0]          dmem_adr,
  input  logic [XLEN-1:0]          dmem_d,
  input  logic                     dmem_we,
  input  logic [2:0]               dmem_size,
  output logic                     dmem_ack,
  output logic [XLEN-1:0]          dmem_q,
  output logic                     dmem_misaligned,
  output logic                     dmem_page_fault,
  output logic                     dmem_overrun,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_adr,
  output logic [XLEN/8-1:0]        mem_be,
  output logic [XLEN-1:0]          mem_d,
  input  logic [XLEN-1:0]          mem_q
);

  localparam int BYTES = XLEN/8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [XLEN:0] LIMIT = (XLEN+1)'(DEPTH * BYTES);

  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic [XLEN-1:0] d;
    logic            we;
    logic [2:0]      size;
  } req_t;

  dmem_state_t state, state_nxt;
  req_t        in_req, pend, cur, sel;
  logic        pend_vld, take;
  logic        sel_mis, sel_oor, cur_mis, cur_oor;
  logic        ack_nxt, mis_nxt, pf_nxt;
  logic [15:0] be_wide;
  logic        unused;

  assign in_req = '{adr: dmem_adr, d: dmem_d, we: dmem_we, size: dmem_size};
  // A buffered request is always older than whatever arrives now
  assign sel    = pend_vld ? pend : in_req;
  assign take   = (state == IDLE) && (pend_vld || dmem_req);

  always_comb begin
    sel_mis = 1'b0;
    case (sel.size)
      BYTE:    sel_mis = 1'b0;
      HWORD:   sel_mis = sel.adr[0];
      WORD:    sel_mis = |sel.adr[1:0];
      DWORD:   sel_mis = (XLEN == 32) || (|sel.adr[2:0]);
      default: sel_mis = 1'b1;
    endcase
    sel_oor = {1'b0, sel.adr} >= LIMIT;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take) begin
          if (sel_mis || sel_oor) state_nxt = ERR;
          else if (sel.we)        state_nxt = WRITE;
          else                    state_nxt = READ;
        end
      end
      READ:    state_nxt = RDATA;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM strobes are gated by rstn so an access is killed on the reset edge itself
  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    ack_nxt = 1'b0;
    mis_nxt = 1'b0;
    pf_nxt  = 1'b0;
    case (state)
      WRITE: begin
        mem_en  = rstn;
        mem_we  = rstn;
        ack_nxt = 1'b1;
      end
      READ:  mem_en  = rstn;
      RDATA: ack_nxt = 1'b1;
      ERR: begin
        ack_nxt = 1'b1;
        mis_nxt = cur_mis;
        pf_nxt  = !cur_mis && cur_oor;
      end
      default: ;
    endcase
  end

  assign mem_adr = cur.adr[OFFW +: AW];
  assign mem_d   = cur.d;
  assign be_wide = 16'(size2be(cur.size)) << cur.adr[OFFW-1:0];
  assign mem_be  = be_wide[BYTES-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dmem_ack        <= 1'b0;
      dmem_misaligned <= 1'b0;
      dmem_page_fault <= 1'b0;
      dmem_overrun    <= 1'b0;
      dmem_q          <= '0;
      pend_vld        <= 1'b0;
    end else begin
      dmem_ack        <= ack_nxt;
      dmem_misaligned <= mis_nxt;
      dmem_page_fault <= pf_nxt;
      if (state == RDATA) dmem_q <= mem_q;
      if (state == IDLE) begin
        if (pend_vld) pend_vld <= dmem_req;
      end else if (dmem_req) begin
        if (pend_vld) dmem_overrun <= 1'b1;
        else          pend_vld     <= 1'b1;
      end
    end
  end

  // Request payloads need no reset; they are only consumed behind valid/state
  always_ff @(posedge clk) begin
    if (take) begin
      cur     <= sel;
      cur_mis <= sel_mis;
      cur_oor <= sel_oor;
    end
    if (dmem_req && (state != IDLE ? !pend_vld : pend_vld)) pend <= in_req;
  end

  assign unused = ^{cur.we, cur.adr, be_wide};

endmodule

// File: tb/tb_pu_riscv_dmem_responder.sv
// Scoreboard bench for pu_riscv_dmem_responder with the SoC-level RAM attached.
module tb_pu_riscv_dmem_responder;
  import pu_riscv_verilog_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dmem_req;
  logic [63:0] dmem_adr, dmem_d;
  logic        dmem_we;
  logic [2:0]  dmem_size;
  logic        dmem_ack, dmem_misaligned, dmem_page_fault, dmem_overrun;
  logic [63:0] dmem_q;
  logic        mem_en, mem_we;
  logic [9:0]  mem_adr;
  logic [7:0]  mem_be;
  logic [63:0] mem_d, mem_q;

  typedef struct {
    int          ack_cyc;
    logic        is_load;
    logic [63:0] q;
    logic        mis;
    logic        pf;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          req_cyc;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] word100;

  pu_riscv_dmem_responder #(.XLEN(64), .DEPTH(1024)) dut (
    .clk(clk), .rstn(rstn), .dmem_req(dmem_req), .dmem_adr(dmem_adr),
    .dmem_d(dmem_d), .dmem_we(dmem_we), .dmem_size(dmem_size),
    .dmem_ack(dmem_ack), .dmem_q(dmem_q), .dmem_misaligned(dmem_misaligned),
    .dmem_page_fault(dmem_page_fault), .dmem_overrun(dmem_overrun),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_be(mem_be),
    .mem_d(mem_d), .mem_q(mem_q)
  );

  pu_riscv_dmem_ram #(.XLEN(64), .DEPTH(1024)) ram (
    .clk(clk), .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_be(mem_be), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Every ack is matched against the oldest expected response
  always begin
    @(posedge clk);
    #1;
    if (dmem_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("[TB] FAIL unexpected_ack at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (cyc !== e.ack_cyc) begin
          n_fail++; $display("[TB] FAIL ack_latency got cycle %0d want %0d", cyc, e.ack_cyc);
        end
        n_checks++;
        if (dmem_misaligned !== e.mis || dmem_page_fault !== e.pf) begin
          n_fail++; $display("[TB] FAIL ack_flags got mis=%b pf=%b want mis=%b pf=%b",
                             dmem_misaligned, dmem_page_fault, e.mis, e.pf);
        end
        if (e.is_load) begin
          n_checks++;
          if (dmem_q !== e.q) begin
            n_fail++; $display("[TB] FAIL load_data got %h want %h", dmem_q, e.q);
          end
        end
      end
    end else if (dmem_misaligned !== 1'b0 || dmem_page_fault !== 1'b0) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL flags_without_ack got mis=%b pf=%b want 0 0", dmem_misaligned, dmem_page_fault);
    end
  end

  task automatic apply_stimulus(input logic [63:0] adr, input logic [63:0] d,
                                input logic we, input logic [2:0] size);
    @(negedge clk);
    dmem_req = 1'b1; dmem_adr = adr; dmem_d = d; dmem_we = we; dmem_size = size;
    req_cyc = cyc;
  endtask

  task automatic release_req();
    @(negedge clk);
    dmem_req = 1'b0;
  endtask

  task automatic expect_ack(input int lat, input logic is_load, input logic [63:0] q,
                            input logic mis, input logic pf);
    exp_q.push_back('{ack_cyc: req_cyc + lat, is_load: is_load, q: q, mis: mis, pf: pf});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain_timeout got %0d outstanding want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; dmem_req = 1'b0; dmem_adr = '0; dmem_d = '0; dmem_we = 1'b0; dmem_size = BYTE;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dmem_ack, dmem_misaligned, dmem_page_fault, dmem_overrun, mem_en, mem_we} !== 6'b0 ||
        dmem_q !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs got ack=%b mis=%b pf=%b ovr=%b en=%b we=%b q=%h want all 0",
               dmem_ack, dmem_misaligned, dmem_page_fault, dmem_overrun, mem_en, mem_we, dmem_q);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store();
    apply_stimulus(64'h104, 64'hDEAD_BEEF_0000_0000, 1'b1, WORD);
    expect_ack(2, 1'b0, '0, 1'b0, 1'b0);
    release_req();
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 8'hF0 || mem_adr !== 10'h20 ||
        mem_d !== 64'hDEAD_BEEF_0000_0000) begin
      n_fail++;
      $display("[TB] FAIL sw_ram_port got en=%b we=%b be=%h adr=%h d=%h want 1 1 f0 020 deadbeef00000000",
               mem_en, mem_we, mem_be, mem_adr, mem_d);
    end
    wait_drain();
  endtask

  task automatic test_load();
    apply_stimulus(64'h100, 64'h0123_4567_89AB_CDEF, 1'b1, DWORD);
    expect_ack(2, 1'b0, '0, 1'b0, 1'b0);
    release_req();
    n_checks++;
    if (mem_be !== 8'hFF || mem_adr !== 10'h20) begin
      n_fail++; $display("[TB] FAIL sd_ram_port got be=%h adr=%h want ff 020", mem_be, mem_adr);
    end
    wait_drain();
    apply_stimulus(64'h100, '0, 1'b0, DWORD);
    expect_ack(3, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    release_req();
    wait_drain();
    apply_stimulus(64'h103, 64'h0000_0000_5500_0000, 1'b1, BYTE);
    expect_ack(2, 1'b0, '0, 1'b0, 1'b0);
    release_req();
    n_checks++;
    if (mem_be !== 8'h08) begin
      n_fail++; $display("[TB] FAIL sb_byte_enable got %h want 08", mem_be);
    end
    wait_drain();
    apply_stimulus(64'h106, 64'hBEEF_0000_0000_0000, 1'b1, HWORD);
    expect_ack(2, 1'b0, '0, 1'b0, 1'b0);
    release_req();
    n_checks++;
    if (mem_be !== 8'hC0) begin
      n_fail++; $display("[TB] FAIL sh_byte_enable got %h want c0", mem_be);
    end
    wait_drain();
    word100 = 64'hBEEF_4567_55AB_CDEF;
    apply_stimulus(64'h100, '0, 1'b0, DWORD);
    expect_ack(3, 1'b1, word100, 1'b0, 1'b0);
    release_req();
    wait_drain();
  endtask

  task automatic test_errors();
    logic [63:0] adrs [6];
    logic [2:0]  sizes [6];
    logic        mis [6];
    logic        en_seen;
    adrs = '{64'h101, 64'h2001, 64'h2000, 64'h2002, 64'h0, 64'h104};
    sizes = '{HWORD, BYTE, BYTE, WORD, UNDEF_SIZE, DWORD};
    mis = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(adrs[i], 64'hFFFF_FFFF_FFFF_FFFF, i[0], sizes[i]);
      expect_ack(2, 1'b0, '0, mis[i], !mis[i]);
      en_seen = 1'b0;
      release_req();
      for (int k = 0; k < 4; k++) begin
        en_seen |= (mem_en !== 1'b0);
        @(negedge clk);
      end
      n_checks++;
      if (en_seen) begin
        n_fail++; $display("[TB] FAIL error_ram_access case %0d got mem_en=1 want 0", i);
      end
      wait_drain();
    end
    n_checks++;
    if (dmem_q !== word100) begin
      n_fail++; $display("[TB] FAIL q_hold got %h want %h", dmem_q, word100);
    end
    apply_stimulus(64'h1FF8, 64'hA5A5_0000_1234_5A5A, 1'b1, DWORD);
    expect_ack(2, 1'b0, '0, 1'b0, 1'b0);
    release_req();
    wait_drain();
    apply_stimulus(64'h1FF8, '0, 1'b0, DWORD);
    expect_ack(3, 1'b1, 64'hA5A5_0000_1234_5A5A, 1'b0, 1'b0);
    release_req();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int c0;
    apply_stimulus(64'h108, 64'h0, 1'b1, DWORD);
    expect_ack(2, 1'b0, '0, 1'b0, 1'b0);
    release_req();
    wait_drain();
    n_checks++;
    if (dmem_overrun !== 1'b0) begin
      n_fail++; $display("[TB] FAIL overrun_early got %b want 0", dmem_overrun);
    end
    apply_stimulus(64'h100, '0, 1'b0, DWORD);
    c0 = req_cyc;
    expect_ack(3, 1'b1, word100, 1'b0, 1'b0);
    apply_stimulus(64'h108, 64'h11, 1'b1, BYTE);
    exp_q.push_back('{ack_cyc: c0 + 5, is_load: 1'b0, q: '0, mis: 1'b0, pf: 1'b0});
    apply_stimulus(64'h109, 64'h2200, 1'b1, BYTE);
    release_req();
    wait_drain();
    n_checks++;
    if (dmem_overrun !== 1'b1) begin
      n_fail++; $display("[TB] FAIL overrun_set got %b want 1", dmem_overrun);
    end
    apply_stimulus(64'h108, '0, 1'b0, DWORD);
    expect_ack(3, 1'b1, 64'h11, 1'b0, 1'b0);
    release_req();
    wait_drain();
  endtask

  task automatic test_reset_abort();
    apply_stimulus(64'h180, 64'h0F0F_1111_2222_3333, 1'b1, DWORD);
    expect_ack(2, 1'b0, '0, 1'b0, 1'b0);
    release_req();
    wait_drain();
    apply_stimulus(64'h180, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1, DWORD);
    @(negedge clk);
    dmem_req = 1'b0;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_ram_strobe got en=%b we=%b want 0 0", mem_en, mem_we);
    end
    @(negedge clk);
    n_checks++;
    if ({dmem_ack, dmem_misaligned, dmem_page_fault, dmem_overrun, mem_en, mem_we} !== 6'b0 ||
        dmem_q !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL abort_reset_outputs got ack=%b mis=%b pf=%b ovr=%b en=%b we=%b q=%h want all 0",
               dmem_ack, dmem_misaligned, dmem_page_fault, dmem_overrun, mem_en, mem_we, dmem_q);
    end
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    apply_stimulus(64'h180, '0, 1'b0, DWORD);
    expect_ack(3, 1'b1, 64'h0F0F_1111_2222_3333, 1'b0, 1'b0);
    release_req();
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pu_riscv_dmem_responder.md
PU_RISCV_DMEM_RESPONDER -- requirements
Module: pu_riscv_dmem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/address width (32 or 64).
REQ-002 SHALL have parameter DEPTH, default 1024, number of XLEN-wide words in the attached RAM.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset: synchronous, active-low.
REQ-005 SHALL have port dmem_req  input  1  one-cycle request strobe from the load/store unit.
REQ-006 SHALL have port dmem_adr  input  XLEN  byte address.
REQ-007 SHALL have port dmem_d  input  XLEN  write data, already lane-shifted by the requester.
REQ-008 SHALL have port dmem_we  input  1  1=store, 0=load.
REQ-009 SHALL have port dmem_size  input  3  BYTE/HWORD/WORD/DWORD/UNDEF_SIZE encoding from the shared package.
REQ-010 SHALL have port dmem_ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port dmem_q  output  XLEN  raw aligned RAM word for loads; unshifted, unextended.
REQ-012 SHALL have port dmem_misaligned  output  1  valid with dmem_ack.
REQ-013 SHALL have port dmem_page_fault  output  1  valid with dmem_ack; signals an out-of-range address.
REQ-014 SHALL have port dmem_overrun  output  1  sticky flag: request lost with the pending buffer full.
REQ-015 SHALL have RAM-side ports mem_en, mem_we (output, 1), mem_adr (output, $clog2(DEPTH)), mem_be (output, XLEN/8), mem_d (output, XLEN), mem_q (input, XLEN); RAM read latency is 1 cycle.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, READ, RDATA, ERR.
REQ-017 SHALL, in IDLE on dmem_req (or when a pending entry exists), latch adr/d/we/size and go to ERR if the access is misaligned or out of range, else to WRITE (we=1) or READ (we=0).
REQ-018 SHALL flag misaligned as: HWORD with adr[0]≠0; WORD with adr[1:0]≠0; DWORD with adr[2:0]≠0; DWORD when XLEN=32; UNDEF_SIZE always. BYTE is never misaligned.
REQ-019 SHALL flag out of range when adr ≥ DEPTH*XLEN/8; misaligned takes priority, and only one flag is set per ack.
REQ-020 SHALL, in WRITE, assert mem_en=mem_we=1, mem_adr=adr word index, mem_d=dmem_d, and mem_be = size mask (1/3/0xF/0xFF) shifted left by the adr byte offset; SHALL pulse dmem_ack in the same cycle; next state IDLE.
REQ-021 SHALL, in READ, assert mem_en=1, mem_we=0; in RDATA, register mem_q into dmem_q and pulse dmem_ack; next state IDLE.
REQ-022 SHALL, in ERR, pulse dmem_ack with the relevant flag, perform no RAM access, and leave dmem_q unchanged; next state IDLE.
REQ-023 Latency from dmem_req: store ack at +2 cycles, load ack at +3 (data on dmem_q at the same edge), error ack at +2.
REQ-024 SHALL hold dmem_q stable until the next load ack.
REQ-025 SHALL hold a one-entry pending buffer that captures a dmem_req arriving while the FSM is not in IDLE; the entry is served on return to IDLE, ahead of any new request.
REQ-026 SHALL, when dmem_req arrives while the buffer is full, drop the request and set dmem_overrun until reset.
REQ-027 SHALL, when dmem_req coincides with the FSM returning to IDLE and the buffer is empty, accept the request directly without loss.
REQ-028 SHALL deassert dmem_misaligned and dmem_page_fault whenever dmem_ack=0.

Reset
REQ-029 SHALL, with rstn=0 at a clock edge, set state=IDLE, clear the pending buffer, and drive dmem_ack=0, dmem_misaligned=0, dmem_page_fault=0, dmem_overrun=0, dmem_q=0, mem_en=0, mem_we=0.
REQ-030 SHALL abort an in-flight access on reset mid-operation: no ack afterwards, no RAM write after the reset edge.

Structure
REQ-031 SHALL import size encodings from pu_riscv_verilog_pkg; FSM state enum and the size-to-byte-mask function SHALL be added to that package.
REQ-032 SHALL place the RAM in one sub-module, pu_riscv_dmem_ram (single port, byte-enable write, 1-cycle read), instantiated at SoC level and not inside this block.

Verification
REQ-033 SW to 0x104, d=0x0000_0000_DEAD_BEEF<<32 (XLEN=64) -> ack at +2, mem_be=0xF0, mem_adr=0x20.
REQ-034 LD from 0x100 after SD 0x0123_4567_89AB_CDEF -> ack at +3, dmem_q=0x0123_4567_89AB_CDEF, no flags.
REQ-035 LH at 0x101 -> ack at +2 with dmem_misaligned=1, mem_en never asserted; LB at 0x2001 with DEPTH=1024 -> dmem_page_fault=1.
REQ-036 Three requests on consecutive cycles (LD, SB, SB) -> first two acked in order, third dropped, dmem_overrun=1.
REQ-037 rstn=0 in the cycle after a store request -> no ack, mem_we stays 0, all outputs at reset values.
